// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE partial-sum datapath.
package pe_pkg;

    localparam int PIXEL_WIDTH_DEF = 16;
    localparam int PSUM_WIDTH_DEF  = 32;
    localparam int CNT_WIDTH_DEF   = 5;

    localparam logic signed [PSUM_WIDTH_DEF-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [PSUM_WIDTH_DEF-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WAIT_PSUM,
        OUTPUT
    } state_t;

endpackage

// File: rtl/sat_adder.sv
// Signed adder that clamps to the W-bit two's-complement range and flags any clamp.
module sat_adder #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] full;

    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        // The top two bits disagree exactly when the true sum leaves the W-bit range.
        ovf  = (full[W] != full[W-1]);
        if (ovf) begin
            sum = full[W] ? MINV : MAXV;
        end else begin
            sum = full[W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a runtime-length window of signed products, optionally adds an upstream psum,
// and hands the saturated result downstream over valid/ready.
module psum_accumulator
    import pe_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int PSUM_WIDTH  = PSUM_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          num_taps,
    input  logic                          psum_in_en,
    input  logic                          prod_valid,
    input  logic signed [2*PIXEL_WIDTH-1:0] product,
    input  logic                          psum_in_valid,
    output logic                          psum_in_ready,
    input  logic signed [PSUM_WIDTH-1:0]  psum_in,
    output logic                          psum_out_valid,
    input  logic                          psum_out_ready,
    output logic signed [PSUM_WIDTH-1:0]  psum_out,
    output logic                          sat_flag,
    output logic                          busy,
    output logic                          drop_err
);

    state_t                       state_q, state_d;
    logic signed [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]         taps_q, taps_d;
    logic                         pen_q, pen_d;
    logic                         sat_q, sat_d;

    logic signed [PSUM_WIDTH-1:0] prod_ext;
    logic signed [PSUM_WIDTH-1:0] add_b;
    logic signed [PSUM_WIDTH-1:0] add_sum;
    logic                         add_ovf;

    assign prod_ext = PSUM_WIDTH'(product);

    // One adder serves both the product run and the final upstream-psum addition.
    sat_adder #(.W(PSUM_WIDTH)) u_sat_adder (
        .a   (acc_q),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        taps_d  = taps_q;
        pen_d   = pen_q;
        sat_d   = sat_q;
        add_b   = prod_ext;
        unique case (state_q)
            IDLE: begin
                if (start && (num_taps != '0)) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    taps_d  = num_taps;
                    pen_d   = psum_in_en;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d = add_sum;
                    sat_d = sat_q | add_ovf;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == taps_q - CNT_WIDTH'(1)) begin
                        state_d = pen_q ? WAIT_PSUM : OUTPUT;
                    end
                end
            end
            WAIT_PSUM: begin
                add_b = psum_in;
                if (psum_in_valid) begin
                    acc_d   = add_sum;
                    sat_d   = sat_q | add_ovf;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (psum_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            taps_q  <= '0;
            pen_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            taps_q  <= taps_d;
            pen_q   <= pen_d;
            sat_q   <= sat_d;
        end
    end

    assign psum_in_ready  = (state_q == WAIT_PSUM);
    assign psum_out_valid = (state_q == OUTPUT);
    assign psum_out       = acc_q;
    assign sat_flag       = sat_q && (state_q == OUTPUT);
    assign busy           = (state_q != IDLE);
    // Products arriving outside the accumulation window are discarded and flagged.
    assign drop_err       = prod_valid && (state_q != ACCUM);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-vector bench with a result scoreboard checked at each output handshake.
module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [4:0]         num_taps;
    logic               psum_in_en;
    logic               prod_valid;
    logic signed [31:0] product;
    logic               psum_in_valid;
    logic               psum_in_ready;
    logic signed [31:0] psum_in;
    logic               psum_out_valid;
    logic               psum_out_ready;
    logic signed [31:0] psum_out;
    logic               sat_flag;
    logic               busy;
    logic               drop_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    psum_accumulator dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_taps       (num_taps),
        .psum_in_en     (psum_in_en),
        .prod_valid     (prod_valid),
        .product        (product),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_in        (psum_in),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .psum_out       (psum_out),
        .sat_flag       (sat_flag),
        .busy           (busy),
        .drop_err       (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && psum_out_valid && psum_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", psum_out);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("sb_psum", psum_out, e[31:0]);
                check("sb_sat", {31'd0, sat_flag}, {31'd0, e[32]});
            end
        end
    end

    task automatic run_window(input int n,
                              input logic signed [31:0] p0, input logic signed [31:0] p1,
                              input logic signed [31:0] p2, input logic signed [31:0] p3,
                              input bit pen, input logic signed [31:0] pin, input int pin_wait,
                              input int hold, input logic signed [31:0] exp_sum, input bit exp_sat);
        logic signed [31:0] pv[4];
        pv = '{p0, p1, p2, p3};
        exp_q.push_back({exp_sat, exp_sum});
        start = 1'b1; num_taps = 5'(n); psum_in_en = pen;
        prod_valid = 1'b1; product = 32'sd1000;
        #1;
        check("drop_on_start", {31'd0, drop_err}, 32'd1);
        tick();
        start = 1'b0;
        check("busy_accum", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            prod_valid = 1'b1;
            product = pv[i];
            tick();
            if (i < n - 1) check("in_ready_accum", {31'd0, psum_in_ready}, 32'd0);
        end
        prod_valid = 1'b0;
        if (pen) begin
            check("in_ready_wait", {31'd0, psum_in_ready}, 32'd1);
            check("valid_in_wait", {31'd0, psum_out_valid}, 32'd0);
            repeat (pin_wait) tick();
            check("in_ready_still", {31'd0, psum_in_ready}, 32'd1);
            psum_in_valid = 1'b1;
            psum_in = pin;
            tick();
            psum_in_valid = 1'b0;
            check("in_ready_after", {31'd0, psum_in_ready}, 32'd0);
        end
        check("valid_latency", {31'd0, psum_out_valid}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'd0, psum_out_valid}, 32'd1);
            check("hold_psum", psum_out, exp_sum);
        end
        psum_out_ready = 1'b1;
        tick();
        psum_out_ready = 1'b0;
        check("valid_drop", {31'd0, psum_out_valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_taps = '0; psum_in_en = 1'b0;
        prod_valid = 1'b0; product = '0; psum_in_valid = 1'b0; psum_in = '0;
        psum_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, psum_in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, psum_out_valid}, 32'd0);
        check("rst_psum", psum_out, 32'd0);
        check("rst_sat", {31'd0, sat_flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {31'd0, drop_err}, 32'd0);
        tick();

        // Plain window held for a few cycles before acceptance.
        run_window(3, 32'sd5, -32'sd2, 32'sd7, 32'sd0, 1'b0, 32'sd0, 0, 3, 32'sd10, 1'b0);
        // Upstream psum added after a delayed delivery.
        run_window(2, 32'sd100, 32'sd200, 32'sd0, 32'sd0, 1'b1, -32'sd50, 4, 0, 32'sd250, 1'b0);
        // Positive saturation, then a clean window clears the sticky flag.
        run_window(2, 32'sh7FFFFFFF, 32'sh10, 32'sd0, 32'sd0, 1'b0, 32'sd0, 0, 0, 32'sh7FFFFFFF, 1'b1);
        run_window(2, 32'sd1, 32'sd1, 32'sd0, 32'sd0, 1'b0, 32'sd0, 0, 0, 32'sd2, 1'b0);
        // Negative saturation through the psum path, then continue from the clamp.
        run_window(1, 32'sh80000000, 32'sd0, 32'sd0, 32'sd0, 1'b1, -32'sd1, 1, 0, 32'sh80000000, 1'b1);
        run_window(3, 32'sh80000000, -32'sd5, 32'sd7, 32'sd0, 1'b0, 32'sd0, 0, 0, 32'sh80000007, 1'b1);

        // Stalled output: start and stray products must not disturb the held result.
        exp_q.push_back({1'b0, 32'sd3});
        start = 1'b1; num_taps = 5'd1; psum_in_en = 1'b0;
        tick();
        start = 1'b0; prod_valid = 1'b1; product = 32'sd3;
        tick();
        prod_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = (k == 1);
            prod_valid = k[0];
            product = 32'sd999;
            #1;
            check("stall_drop", {31'd0, drop_err}, {31'd0, k[0]});
            tick();
            check("stall_psum", psum_out, 32'sd3);
            check("stall_valid", {31'd0, psum_out_valid}, 32'd1);
        end
        prod_valid = 1'b0;
        start = 1'b1;
        psum_out_ready = 1'b1;
        tick();
        start = 1'b0; psum_out_ready = 1'b0;
        check("hs_start_ignored", {31'd0, busy}, 32'd0);
        tick();
        check("hs_start_still_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a window abandons it.
        start = 1'b1; num_taps = 5'd4; psum_in_en = 1'b0;
        tick();
        start = 1'b0; prod_valid = 1'b1; product = 32'sd11;
        tick();
        prod_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, psum_out_valid}, 32'd0);
        check("mid_rst_psum", psum_out, 32'd0);
        check("mid_rst_in_ready", {31'd0, psum_in_ready}, 32'd0);
        check("mid_rst_sat", {31'd0, sat_flag}, 32'd0);
        run_window(1, -32'sd9, 32'sd0, 32'sd0, 32'sd0, 1'b0, 32'sd0, 0, 0, -32'sd9, 1'b0);

        // Zero-length window is refused.
        start = 1'b1; num_taps = 5'd0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("zero_taps_busy", {31'd0, busy}, 32'd0);
            check("zero_taps_valid", {31'd0, psum_out_valid}, 32'd0);
            tick();
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
